// File: rtl/ram_rd_pkg.sv
// Shared types and sizing helpers for the LUT-RAM stream reader.
package ram_rd_pkg;

  localparam int unsigned A_WIDTH_DEF = 3;
  localparam int unsigned D_WIDTH_DEF = 8;

  // Controller states: waiting for a command, walking the range, emptying the output register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Number of words addressable with a_width address bits.
  function automatic int unsigned depth_of(input int unsigned a_width);
    return 32'd1 << a_width;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register carrying a data word and a last-beat flag.
module stream_out_reg #(
  parameter int unsigned D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);

  logic [D_WIDTH-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;

  // Load when empty or when the held word leaves this cycle; otherwise hold or empty out.
  always_comb begin
    in_ready = !valid_q || out_ready;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    if (in_valid && in_ready) begin
      data_d  = in_data;
      valid_d = 1'b1;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  // Register stage; reset clears the held word so no stale beat survives.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side controller: walks a wrapping address range of an async-read LUT RAM
// and streams each word out through a one-entry valid/ready register.
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   len,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] r_add,
  input  logic [D_WIDTH-1:0] r_data,
  output logic [D_WIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last
);

  localparam logic [A_WIDTH:0] ONE_LEFT = (A_WIDTH+1)'(1);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] r_add_q, r_add_d;
  logic [A_WIDTH:0]   remaining_q, remaining_d;
  logic               done_q, done_d;

  logic load_ok;
  logic cap;
  logic final_word;

  assign final_word = (remaining_q == ONE_LEFT);
  assign cap        = (state_q == READ) && load_ok;

  stream_out_reg #(
    .D_WIDTH (D_WIDTH)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state_q == READ),
    .in_data   (r_data),
    .in_last   (final_word),
    .in_ready  (load_ok),
    .out_data  (m_data),
    .out_valid (m_valid),
    .out_last  (m_last),
    .out_ready (m_ready)
  );

  // Next-state, address and word-count logic for the burst walker.
  always_comb begin
    state_d     = state_q;
    r_add_d     = r_add_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            r_add_d     = base_addr;
            remaining_d = len;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (cap) begin
          // Address wraps naturally at the top of the memory.
          r_add_d     = r_add_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (final_word) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_add_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_add_q     <= r_add_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign r_add = r_add_q;

endmodule
